ibex_rf_wb_arbiter: RTL and testbench

IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

---
 rtl/ibex_rf_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter
// Shares the single register-file write port between execute-stage writes and
// load writebacks. Execute writes normally win. A load that loses is parked in
// a 2-entry in-order queue, drained when the port is free or when the head has
// waited StarveLimit cycles. Queued values are forwarded to the two read ports.
//
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   ex_we_i/ex_waddr_i/ex_wdata_i         execute write request
//   ex_ready_o                            execute write accepted this cycle
//   lsu_we_i/lsu_waddr_i/lsu_wdata_i      load writeback request
//   lsu_ready_o                           load writeback accepted this cycle
//   we_a_o/waddr_a_o/wdata_a_o            register-file write port
//   raddr_a_i/raddr_b_i                   read addresses to snoop
//   fwd_hit_x_o/fwd_data_x_o              forwarding from the queue
//   wb_pending_o                          queue non-empty
module ibex_rf_wb_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned StarveLimit = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_we_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  output logic                 we_a_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_hit_a_o,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
  output logic                 wb_pending_o
);

  typedef struct packed {
    logic                 valid;
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  localparam logic [2:0] StarveMax = 3'(StarveLimit);

  // Entry 0 is always the head; the next-state logic keeps the queue compacted
  // so a valid entry 1 implies a valid entry 0.
  entry_t     q_reg [2];
  entry_t     q_next [2];
  logic [2:0] starve_reg, starve_next;

  logic       pending, q_arb, ex_valid, lsu_valid;
  logic       case_a, drive_ex, drive_lsu, pop, free_after_pop, enq;
  logic       keep0, keep1;
  logic [1:0] inv;
  logic [1:0] count;
  entry_t     lsu_entry;

  assign pending      = q_reg[0].valid | q_reg[1].valid;
  assign wb_pending_o = pending;
  assign count        = {1'b0, q_reg[0].valid} + {1'b0, q_reg[1].valid};

  // Address-0 requests are no-ops; nothing competes for the port during reset
  // so queued entries are discarded rather than written.
  assign q_arb     = pending && !rst_i;
  assign ex_valid  = ex_we_i && (ex_waddr_i != 5'd0) && !rst_i;
  assign lsu_valid = lsu_we_i && (lsu_waddr_i != 5'd0) && !rst_i;

  assign case_a    = q_arb && (starve_reg == StarveMax);
  assign drive_ex  = !case_a && ex_valid;
  assign pop       = case_a || (!drive_ex && q_arb);
  assign drive_lsu = !case_a && !drive_ex && !q_arb && lsu_valid;

  assign free_after_pop = (count != 2'd2) || pop;

  assign ex_ready_o  = !case_a;
  assign lsu_ready_o = (lsu_we_i && (lsu_waddr_i == 5'd0)) || drive_lsu || free_after_pop;

  // A matching execute write in the same cycle makes the load value stale.
  assign enq = lsu_valid && !drive_lsu && free_after_pop &&
               !(drive_ex && (ex_waddr_i == lsu_waddr_i));

  assign lsu_entry = '{valid: 1'b1, addr: lsu_waddr_i, data: lsu_wdata_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inv
      assign inv[gi] = drive_ex && q_reg[gi].valid && (q_reg[gi].addr == ex_waddr_i);
    end
  endgenerate

  assign keep0 = q_reg[0].valid && !pop && !inv[0];
  assign keep1 = q_reg[1].valid && !inv[1];

  // Write-port mux.
  always_comb begin
    we_a_o    = 1'b0;
    waddr_a_o = 5'd0;
    wdata_a_o = '0;
    if (pop) begin
      we_a_o    = 1'b1;
      waddr_a_o = q_reg[0].addr;
      wdata_a_o = q_reg[0].data;
    end else if (drive_ex) begin
      we_a_o    = 1'b1;
      waddr_a_o = ex_waddr_i;
      wdata_a_o = ex_wdata_i;
    end else if (drive_lsu) begin
      we_a_o    = 1'b1;
      waddr_a_o = lsu_waddr_i;
      wdata_a_o = lsu_wdata_i;
    end
  end

  // Queue next state: drop popped/invalidated entries, compact, append tail.
  always_comb begin
    q_next[0]       = q_reg[0];
    q_next[1]       = q_reg[1];
    q_next[0].valid = 1'b0;
    q_next[1].valid = 1'b0;
    if (keep0) begin
      q_next[0] = q_reg[0];
      if (keep1)    q_next[1] = q_reg[1];
      else if (enq) q_next[1] = lsu_entry;
    end else if (keep1) begin
      q_next[0] = q_reg[1];
      if (enq) q_next[1] = lsu_entry;
    end else if (enq) begin
      q_next[0] = lsu_entry;
    end
  end

  always_comb begin
    starve_next = starve_reg;
    if (!pending || pop)            starve_next = 3'd0;
    else if (starve_reg < StarveMax) starve_next = starve_reg + 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_reg[0].valid <= 1'b0;
      q_reg[1].valid <= 1'b0;
      starve_reg     <= 3'd0;
    end else begin
      q_reg[0]   <= q_next[0];
      q_reg[1]   <= q_next[1];
      starve_reg <= starve_next;
    end
  end

  // Forwarding: the tail (entry 1) is the youngest, so it takes precedence.
  logic [4:0]           raddr    [2];
  logic                 hit      [2];
  logic [DataWidth-1:0] hit_data [2];

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic m0, m1;
      assign m0 = q_reg[0].valid && (q_reg[0].addr == raddr[gi]);
      assign m1 = q_reg[1].valid && (q_reg[1].addr == raddr[gi]);
      assign hit[gi] = (raddr[gi] != 5'd0) && (m0 || m1);
      assign hit_data[gi] = !hit[gi] ? '0 : (m1 ? q_reg[1].data : q_reg[0].data);
    end
  endgenerate

  assign fwd_hit_a_o  = hit[0];
  assign fwd_hit_b_o  = hit[1];
  assign fwd_data_a_o = hit_data[0];
  assign fwd_data_b_o = hit_data[1];

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Table-driven bench for ibex_rf_wb_arbiter (DataWidth=32, StarveLimit=3).
// Each record is one clock cycle: inputs are driven just after the rising edge,
// the expected outputs are pushed to a scoreboard queue, and at the falling
// edge the record is popped and compared against the combinational outputs.
module tb_ibex_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we, lsu_we, we_a, ex_ready, lsu_ready, pending;
  logic [4:0]  ex_waddr, lsu_waddr, waddr_a, raddr_a, raddr_b;
  logic [31:0] ex_wdata, lsu_wdata, wdata_a, fwd_data_a, fwd_data_b;
  logic        fwd_hit_a, fwd_hit_b;

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.DataWidth(32), .StarveLimit(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
    .we_a_o(we_a), .waddr_a_o(waddr_a), .wdata_a_o(wdata_a),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .fwd_hit_a_o(fwd_hit_a), .fwd_hit_b_o(fwd_hit_b),
    .fwd_data_a_o(fwd_data_a), .fwd_data_b_o(fwd_data_b),
    .wb_pending_o(pending)
  );

  typedef struct {
    string       name;
    logic        rst, exw;  logic [4:0] exa; logic [31:0] exd;
    logic        lw;        logic [4:0] la;  logic [31:0] ld;
    logic [4:0]  ra, rb;
    logic        we;        logic [4:0] wa;  logic [31:0] wd;
    logic        exr, lr, pend, ha; logic [31:0] da;
    logic        hb;        logic [31:0] db;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input string n, input logic r, input logic exw, input logic [4:0] exa,
                     input logic [31:0] exd, input logic lw, input logic [4:0] la,
                     input logic [31:0] ld, input logic [4:0] ra, input logic [4:0] rb,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic exr, input logic lr, input logic pend,
                     input logic ha, input logic [31:0] da, input logic hb, input logic [31:0] db);
    vec_t v;
    v.name = n; v.rst = r; v.exw = exw; v.exa = exa; v.exd = exd;
    v.lw = lw; v.la = la; v.ld = ld; v.ra = ra; v.rb = rb;
    v.we = we; v.wa = wa; v.wd = wd; v.exr = exr; v.lr = lr; v.pend = pend;
    v.ha = ha; v.da = da; v.hb = hb; v.db = db;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s got=0x%0h expected=0x%0h", n, f, act, exp);
    end
  endtask

  initial begin
    //   name        rst exw exa exd    lw la  ld      ra rb   we wa  wd     exr lr pend ha da      hb db
    add("reset",     0, 0, 0,  0,     0, 0,  0,      0, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("ex5_lsu6",  0, 1, 5,  'hA,   1, 6,  'hB,    6, 0,   1, 5,  'hA,   1, 1, 0,   0, 0,      0, 0);
    add("drain6",    0, 0, 0,  0,     0, 0,  0,      6, 5,   1, 6,  'hB,   1, 1, 1,   1, 'hB,    0, 0);
    add("empty1",    0, 0, 0,  0,     0, 0,  0,      6, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("lsu_x0",    0, 0, 0,  0,     1, 0,  'h55,   0, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("after_x0",  0, 0, 0,  0,     0, 0,  0,      0, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("st_enq9",   0, 1, 7,  1,     1, 9,  'h99,   0, 0,   1, 7,  1,     1, 1, 0,   0, 0,      0, 0);
    add("st_lose1",  0, 1, 7,  2,     0, 0,  0,      9, 0,   1, 7,  2,     1, 1, 1,   1, 'h99,   0, 0);
    add("st_lose2",  0, 1, 7,  3,     0, 0,  0,      0, 0,   1, 7,  3,     1, 1, 1,   0, 0,      0, 0);
    add("st_lose3",  0, 1, 7,  4,     0, 0,  0,      0, 0,   1, 7,  4,     1, 1, 1,   0, 0,      0, 0);
    add("st_win9",   0, 1, 7,  5,     0, 0,  0,      0, 0,   1, 9,  'h99,  0, 1, 1,   0, 0,      0, 0);
    add("st_empty",  0, 0, 0,  0,     0, 0,  0,      0, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("f_enq3",    0, 1, 1,  'h10,  1, 3,  'h33,   0, 0,   1, 1,  'h10,  1, 1, 0,   0, 0,      0, 0);
    add("f_enq4",    0, 1, 2,  'h20,  1, 4,  'h44,   3, 0,   1, 2,  'h20,  1, 1, 1,   1, 'h33,   0, 0);
    add("f_full1",   0, 1, 1,  'h11,  1, 8,  'h88,   3, 4,   1, 1,  'h11,  1, 0, 1,   1, 'h33,   1, 'h44);
    add("f_full2",   0, 1, 1,  'h12,  1, 8,  'h88,   3, 4,   1, 1,  'h12,  1, 0, 1,   1, 'h33,   1, 'h44);
    add("f_starve",  0, 1, 1,  'h13,  1, 8,  'h88,   3, 4,   1, 3,  'h33,  0, 1, 1,   1, 'h33,   1, 'h44);
    add("f_pop4",    0, 0, 0,  0,     0, 0,  0,      8, 4,   1, 4,  'h44,  1, 1, 1,   1, 'h88,   1, 'h44);
    add("f_pop8",    0, 0, 0,  0,     0, 0,  0,      8, 0,   1, 8,  'h88,  1, 1, 1,   1, 'h88,   0, 0);
    add("f_empty",   0, 0, 0,  0,     0, 0,  0,      8, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("i_enq11",   0, 1, 1,  1,     1, 3,  'h11,   0, 0,   1, 1,  1,     1, 1, 0,   0, 0,      0, 0);
    add("i_enq22",   0, 1, 2,  2,     1, 3,  'h22,   3, 0,   1, 2,  2,     1, 1, 1,   1, 'h11,   0, 0);
    add("i_inval",   0, 1, 3,  'h33,  0, 0,  0,      3, 0,   1, 3,  'h33,  1, 0, 1,   1, 'h22,   0, 0);
    add("i_gone",    0, 0, 0,  0,     0, 0,  0,      3, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("r_enq5",    0, 1, 1,  1,     1, 5,  'h55,   0, 0,   1, 1,  1,     1, 1, 0,   0, 0,      0, 0);
    add("r_enq6",    0, 1, 2,  2,     1, 6,  'h66,   0, 0,   1, 2,  2,     1, 1, 1,   0, 0,      0, 0);
    add("r_reset",   1, 0, 0,  0,     0, 0,  0,      5, 6,   0, 0,  0,     1, 0, 1,   1, 'h55,   1, 'h66);
    add("r_after1",  0, 0, 0,  0,     0, 0,  0,      5, 6,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("r_after2",  0, 0, 0,  0,     0, 0,  0,      0, 0,   0, 0,  0,     1, 1, 0,   0, 0,      0, 0);
    add("d_lsu10",   0, 0, 0,  0,     1, 10, 'hAA,   10, 0,  1, 10, 'hAA,  1, 1, 0,   0, 0,      0, 0);
    add("d_ex0",     0, 1, 0,  5,     1, 11, 'hBB,   10, 0,  1, 11, 'hBB,  1, 1, 0,   0, 0,      0, 0);
    add("c_same12",  0, 1, 12, 1,     1, 12, 2,      0, 0,   1, 12, 1,     1, 1, 0,   0, 0,      0, 0);
    add("c_after",   0, 0, 0,  0,     0, 0,  0,      12, 0,  0, 0,  0,     1, 1, 0,   0, 0,      0, 0);

    rst = 1'b1; ex_we = 0; ex_waddr = 0; ex_wdata = 0;
    lsu_we = 0; lsu_waddr = 0; lsu_wdata = 0; raddr_a = 0; raddr_b = 0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      vec_t e;
      @(posedge clk); #1;
      rst = vecs[i].rst;
      ex_we = vecs[i].exw; ex_waddr = vecs[i].exa; ex_wdata = vecs[i].exd;
      lsu_we = vecs[i].lw; lsu_waddr = vecs[i].la; lsu_wdata = vecs[i].ld;
      raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk(e.name, "we",    32'(we_a),       32'(e.we));
      chk(e.name, "waddr", 32'(waddr_a),    32'(e.wa));
      chk(e.name, "wdata", wdata_a,         e.wd);
      chk(e.name, "exrdy", 32'(ex_ready),   32'(e.exr));
      chk(e.name, "lsurdy",32'(lsu_ready),  32'(e.lr));
      chk(e.name, "pend",  32'(pending),    32'(e.pend));
      chk(e.name, "hita",  32'(fwd_hit_a),  32'(e.ha));
      chk(e.name, "dataa", fwd_data_a,      e.da);
      chk(e.name, "hitb",  32'(fwd_hit_b),  32'(e.hb));
      chk(e.name, "datab", fwd_data_b,      e.db);
      $display("[TB] %-9s we=%0d a=%0d d=0x%0h exr=%0d lr=%0d pend=%0d", e.name,
               we_a, waddr_a, wdata_a, ex_ready, lsu_ready, pending);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
